hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write (hold) and reset (flush/bubble) inputs of the PC and of the IF_ID, ID_EX and EX_MEM pipeline registers.
- Resolves four hazard classes:
  - data-memory wait, by freezing the pipeline;
  - taken redirect from MEM, by flushing the three younger stages;
  - multi-cycle EX operation, using a counted stall;
  - load-use, by inserting a one-cycle bubble.
- Also keeps saturating stall and flush performance counters.

Parameters:
- MC_LAT, 4: EX occupancy in cycles of a multi-cycle op; legal values are 2 to 16.
- CNT_W, 32: width of each performance counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of the instruction in IF_ID
- id_rt  in  5  rt field of the instruction in IF_ID
- id_uses_rt  in  1  the ID instruction reads rt as a source
- ex_MemRead  in  1  MemRead_out of ID_EX
- ex_RT  in  5  RT_out of ID_EX
- ex_multicycle  in  1  the op held in ID_EX needs MC_LAT EX cycles
- mem_PCsrc  in  2  PCsrc from EX_MEM; nonzero means a taken redirect
- dmem_busy  in  1  data memory not ready
- PC_write  out  1  PC load enable
- IF_ID_write  out  1  IF_ID write enable
- IF_ID_reset  out  1  IF_ID flush
- ID_EX_write  out  1  ID_EX write enable
- ID_EX_reset  out  1  ID_EX flush (bubble)
- EX_MEM_write  out  1  EX_MEM write enable
- EX_MEM_reset  out  1  EX_MEM flush (bubble)
- stall_count  out  CNT_W  cycles lost to stalls
- flush_count  out  CNT_W  redirects taken

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Output timing: control outputs are combinational from state and inputs (Mealy). The counters are registered.
- Default RUN outputs: all *_write = 1 and all *_reset = 0.
- While reset = 1:
  - control outputs are forced to all *_write = 0 and all *_reset = 1;
  - the FSM goes to RUN and cnt goes to 0;
  - both counters clear to 0.
- States: RUN and MC_BUSY. A 4-bit down-counter cnt is used in MC_BUSY.
- Evaluation order each cycle, highest priority first. Only the first matching rule applies.
  1. dmem_busy = 1 (freeze):
     - all *_write = 0 and all *_reset = 0;
     - state and cnt hold;
     - stall_count increments.
  2. mem_PCsrc != 0 (redirect):
     - PC_write = 1;
     - IF_ID_reset = 1, ID_EX_reset = 1, EX_MEM_reset = 1;
     - the next state is RUN and cnt is cleared, which aborts any multi-cycle op;
     - flush_count increments.
  3. State MC_BUSY, cnt != 0:
     - PC_write = IF_ID_write = ID_EX_write = 0;
     - EX_MEM_reset = 1;
     - cnt decrements;
     - stall_count increments.
  4. State MC_BUSY, cnt == 0 (release):
     - default outputs, so the op advances;
     - the next state is RUN;
     - ex_multicycle is ignored in this cycle.
  5. State RUN with ex_multicycle = 1:
     - same outputs as rule 3;
     - cnt is loaded with MC_LAT-2 and the next state is MC_BUSY;
     - stall_count increments.
     - Total stall is MC_LAT-1 cycles; the op leaves EX on its MC_LAT-th cycle.
  6. Load-use. Condition: state RUN, ex_MemRead = 1, ex_RT != 0, and either ex_RT == id_rs or (id_uses_rt = 1 and ex_RT == id_rt).
     - PC_write = IF_ID_write = 0;
     - ID_EX_reset = 1;
     - stall_count increments.
     - It lasts exactly one cycle because the bubble clears ex_MemRead.
  7. Otherwise: default outputs.
- Register 0 never causes a load-use stall.
- Counters saturate at all-ones and do not wrap.
- A redirect held in EX_MEM during a freeze is not acted on until dmem_busy falls. The redirect stays asserted because EX_MEM is frozen.
- Back-to-back multi-cycle ops: after a release in MC_BUSY, the next op retriggers the stall from RUN.

Test Plan:
- Load-use: ex_MemRead=1, ex_RT=5, id_rs=5 -> one cycle with PC_write=0, IF_ID_write=0, ID_EX_reset=1; next cycle (ex_MemRead=0) -> defaults; stall_count=1.
- Load-use on register 0: ex_MemRead=1, ex_RT=0, id_rs=0 -> no stall. Load-use on rt with id_uses_rt=0 and ex_RT=id_rt=7 -> no stall.
- Multi-cycle op with MC_LAT=4, ex_multicycle held 1 -> exactly 3 stall cycles with EX_MEM_reset=1, then 1 release cycle; stall_count=3. Repeat with a back-to-back op -> 3 further stalls.
- Redirect mid-multicycle: mem_PCsrc=2'b01 on the 2nd stall cycle -> that cycle IF_ID_reset, ID_EX_reset and EX_MEM_reset are all 1 and PC_write=1; next state RUN; flush_count=1.
- Freeze priority: dmem_busy=1 for 5 cycles with mem_PCsrc=1 and a load-use present -> all writes and resets 0 for 5 cycles and stall_count=5; on the cycle dmem_busy falls -> flush asserted.
- Reset mid-MC_BUSY, and counter saturation with CNT_W=4 -> after reset, state RUN, counters 0, outputs default; after 20 stalls, stall_count=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: freeze, redirect flush, multi-cycle stall, load-use bubble
// Mealy control outputs from a RUN/MC_BUSY FSM plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_RT,
  input  logic             ex_multicycle,
  input  logic [1:0]       mem_PCsrc,
  input  logic             dmem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_reset,
  output logic             ID_EX_write,
  output logic             ID_EX_reset,
  output logic             EX_MEM_write,
  output logic             EX_MEM_reset,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  // The triggering cycle counts as the first stall, so cnt starts two short.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             stall_inc, flush_inc, load_use;

  assign load_use = ex_MemRead && (ex_RT != 5'd0) &&
                    ((ex_RT == id_rs) || (id_uses_rt && (ex_RT == id_rt)));

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_reset  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_reset  = 1'b0;
    EX_MEM_write = 1'b1;
    EX_MEM_reset = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_reset  = 1'b1;
      ID_EX_write  = 1'b0;
      ID_EX_reset  = 1'b1;
      EX_MEM_write = 1'b0;
      EX_MEM_reset = 1'b1;
      state_d      = RUN;
      cnt_d        = 4'd0;
    end else if (dmem_busy) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      stall_inc    = 1'b1;
    end else if (mem_PCsrc != 2'b00) begin
      IF_ID_reset  = 1'b1;
      ID_EX_reset  = 1'b1;
      EX_MEM_reset = 1'b1;
      state_d      = RUN;
      cnt_d        = 4'd0;
      flush_inc    = 1'b1;
    end else if (state_q == MC_BUSY) begin
      if (cnt_q != 4'd0) begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_write  = 1'b0;
        EX_MEM_reset = 1'b1;
        cnt_d        = cnt_q - 4'd1;
        stall_inc    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (ex_multicycle) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_reset = 1'b1;
      cnt_d        = MC_LOAD;
      state_d      = MC_BUSY;
      stall_inc    = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_reset  = 1'b1;
      stall_inc    = 1'b1;
    end

    stall_count_d = (stall_inc && (stall_count_q != '1)) ? stall_count_q + 1'b1 : stall_count_q;
    flush_count_d = (flush_inc && (flush_count_q != '1)) ? flush_count_q + 1'b1 : flush_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
// Control outputs packed as {PC_w, IFID_w, IFID_r, IDEX_w, IDEX_r, EXMEM_w, EXMEM_r}.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_RT;
  logic        id_uses_rt, ex_MemRead, ex_multicycle, dmem_busy;
  logic [1:0]  mem_PCsrc;
  logic        PC_write, IF_ID_write, IF_ID_reset, ID_EX_write, ID_EX_reset, EX_MEM_write, EX_MEM_reset;
  logic [31:0] stall_count, flush_count;
  logic        s_pcw, s_ifw, s_ifr, s_idw, s_idr, s_exw, s_exr;
  logic [3:0]  s_stall, s_flush;
  logic [6:0]  ctrl;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  localparam logic [6:0] C_DEF    = 7'b1101010;
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_MC     = 7'b0000011;
  localparam logic [6:0] C_FLUSH  = 7'b1111111;
  localparam logic [6:0] C_LU     = 7'b0001110;

  always #5 clock = ~clock;

  assign ctrl = {PC_write, IF_ID_write, IF_ID_reset, ID_EX_write, ID_EX_reset, EX_MEM_write, EX_MEM_reset};

  hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RT(ex_RT), .ex_multicycle(ex_multicycle),
    .mem_PCsrc(mem_PCsrc), .dmem_busy(dmem_busy),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_reset(IF_ID_reset),
    .ID_EX_write(ID_EX_write), .ID_EX_reset(ID_EX_reset),
    .EX_MEM_write(EX_MEM_write), .EX_MEM_reset(EX_MEM_reset),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.MC_LAT(4), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_RT(ex_RT), .ex_multicycle(ex_multicycle),
    .mem_PCsrc(mem_PCsrc), .dmem_busy(dmem_busy),
    .PC_write(s_pcw), .IF_ID_write(s_ifw), .IF_ID_reset(s_ifr),
    .ID_EX_write(s_idw), .ID_EX_reset(s_idr),
    .EX_MEM_write(s_exw), .EX_MEM_reset(s_exr),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_RT = 5'd9; ex_multicycle = 1'b0;
    mem_PCsrc = 2'b00; dmem_busy = 1'b0;
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 2 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    settle();
    checks++;
    if (ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RST); end
    tick(); tick();
    reset = 1'b0;
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL reset_default: got %b want %b", ctrl, C_DEF); end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_count, flush_count);
    end
  endtask

  task automatic test_load_use();
    tick();
    ex_MemRead = 1'b1; ex_RT = 5'd5; id_rs = 5'd5;
    settle();
    checks++;
    if (ctrl !== C_LU) begin errors++; $display("FAIL load_use_rs: got %b want %b", ctrl, C_LU); end
    exp_stall++;
    tick();
    ex_MemRead = 1'b0;
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL load_use_after: got %b want %b", ctrl, C_DEF); end
    checks++;
    if (stall_count !== 32'(exp_stall)) begin errors++; $display("FAIL load_use_count: got %0d want %0d", stall_count, exp_stall); end
  endtask

  task automatic test_load_use_exempt();
    ex_MemRead = 1'b1; ex_RT = 5'd0; id_rs = 5'd0;
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL load_use_r0: got %b want %b", ctrl, C_DEF); end
    ex_RT = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL load_use_rt_unused: got %b want %b", ctrl, C_DEF); end
    id_uses_rt = 1'b1;
    settle();
    checks++;
    if (ctrl !== C_LU) begin errors++; $display("FAIL load_use_rt: got %b want %b", ctrl, C_LU); end
    exp_stall++;
    tick();
    idle();
    settle();
  endtask

  task automatic test_multicycle();
    ex_multicycle = 1'b1;
    for (int op = 0; op < 2; op++) begin
      for (int c = 0; c < 3; c++) begin
        settle();
        checks++;
        if (ctrl !== C_MC) begin errors++; $display("FAIL mc_stall op%0d cyc%0d: got %b want %b", op, c, ctrl, C_MC); end
        exp_stall++;
        tick();
      end
      settle();
      checks++;
      if (ctrl !== C_DEF) begin errors++; $display("FAIL mc_release op%0d: got %b want %b", op, ctrl, C_DEF); end
      tick();
      checks++;
      if (stall_count !== 32'(exp_stall)) begin errors++; $display("FAIL mc_count op%0d: got %0d want %0d", op, stall_count, exp_stall); end
    end
    idle();
    settle();
  endtask

  task automatic test_redirect_mid_mc();
    ex_multicycle = 1'b1;
    settle();
    exp_stall++;
    tick();
    mem_PCsrc = 2'b01;
    settle();
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("FAIL redirect_mc: got %b want %b", ctrl, C_FLUSH); end
    exp_flush++;
    tick();
    idle();
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL redirect_back_to_run: got %b want %b", ctrl, C_DEF); end
    checks++;
    if (flush_count !== 32'(exp_flush) || stall_count !== 32'(exp_stall)) begin
      errors++; $display("FAIL redirect_counts: got flush=%0d stall=%0d want %0d %0d", flush_count, stall_count, exp_flush, exp_stall);
    end
  endtask

  task automatic test_freeze_priority();
    dmem_busy = 1'b1; mem_PCsrc = 2'b01;
    ex_MemRead = 1'b1; ex_RT = 5'd4; id_rs = 5'd4;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (ctrl !== C_FREEZE) begin errors++; $display("FAIL freeze cyc%0d: got %b want %b", c, ctrl, C_FREEZE); end
      exp_stall++;
      tick();
    end
    dmem_busy = 1'b0;
    settle();
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("FAIL freeze_release_flush: got %b want %b", ctrl, C_FLUSH); end
    exp_flush++;
    tick();
    idle();
    settle();
    checks++;
    if (stall_count !== 32'(exp_stall) || flush_count !== 32'(exp_flush)) begin
      errors++; $display("FAIL freeze_counts: got stall=%0d flush=%0d want %0d %0d", stall_count, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_mc_and_saturation();
    ex_multicycle = 1'b1;
    tick(); tick();
    reset = 1'b1;
    settle();
    checks++;
    if (ctrl !== C_RST) begin errors++; $display("FAIL reset_mid_mc_ctrl: got %b want %b", ctrl, C_RST); end
    tick();
    reset = 1'b0;
    idle();
    settle();
    checks++;
    if (ctrl !== C_DEF) begin errors++; $display("FAIL reset_mid_mc_run: got %b want %b", ctrl, C_DEF); end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0 || s_stall !== 4'd0) begin
      errors++; $display("FAIL reset_mid_mc_counters: got %0d %0d %0d want 0 0 0", stall_count, flush_count, s_stall);
    end
    ex_MemRead = 1'b1; ex_RT = 5'd6; id_rs = 5'd6;
    for (int c = 0; c < 20; c++) tick();
    idle();
    settle();
    checks++;
    if (s_stall !== 4'd15) begin errors++; $display("FAIL saturation_w4: got %0d want 15", s_stall); end
    checks++;
    if (stall_count !== 32'd20) begin errors++; $display("FAIL stall_count_w32: got %0d want 20", stall_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_load_use_exempt();
    test_multicycle();
    test_redirect_mid_mc();
    test_freeze_priority();
    test_reset_mid_mc_and_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
